// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell reused LSB-first computes
// a - b - bin over WIDTH clocks, with the result held until the next start.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_borrowNext;
    logic [WIDTH-1:0] w_diffShift;

    assign w_accept     = ((r_state == IDLE) || (r_state == DONE)) && i_start;
    assign w_last       = (r_count == CW'(WIDTH - 1));
    assign w_d          = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_borrowNext = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);

    // New bit enters at the MSB so the LSB ends up in diff[0] after WIDTH shifts.
    always_comb begin
        w_diffShift            = r_diff >> 1;
        w_diffShift[WIDTH-1]   = w_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = i_start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = i_start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_borrow <= i_bin;
            r_count  <= '0;
        end else if (r_state == RUN) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_borrow <= w_borrowNext;
            r_count  <= r_count + CW'(1);
            r_diff   <= w_diffShift;
            // Borrow-out is published separately so it stays stable while a new op runs.
            if (w_last) begin
                r_bout <= w_borrowNext;
            end
        end
    end

    assign o_busy = (r_state == RUN);
    assign o_done = (r_state == DONE);
    assign o_diff = r_diff;
    assign o_bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes the expected
// {bout,diff}, a monitor pops and compares on every done pulse.
module tb_serial_subtractor;

   localparam int WIDTH = 4;

   logic             clock;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   logic [WIDTH:0]   expQueue[$];
   int               checks = 0;
   int               failures = 0;
   int               doneCount = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk(clock),
      .rst_n(rst_n),
      .i_start(start),
      .i_a(a),
      .i_b(b),
      .i_bin(bin),
      .o_busy(busy),
      .o_done(done),
      .o_diff(diff),
      .o_bout(bout)
   );

   // Free-running clock, 10 time units per period
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Monitor: on each done pulse pop the oldest expected result and compare
   always @(negedge clock) begin
      if (rst_n && done) begin
         doneCount++;
         checks++;
         if (expQueue.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_done got=%b_%h expected=none", bout, diff);
         end else begin
            logic [WIDTH:0] expVal;
            expVal = expQueue.pop_front();
            if ({bout, diff} !== expVal) begin
               failures++;
               $display("[TB] FAIL result got={bout,diff}=%b_%h expected=%b_%h",
                        bout, diff, expVal[WIDTH], expVal[WIDTH-1:0]);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expVal);
      checks++;
      if (got !== expVal) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h", name, got, expVal);
      end
   endtask

   // Issue one operation with a single-cycle start pulse and queue its result
   task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                input logic tbin, input logic [WIDTH-1:0] expDiff,
                                input logic expBout);
      @(negedge clock);
      a     = ta;
      b     = tb;
      bin   = tbin;
      start = 1'b1;
      expQueue.push_back({expBout, expDiff});
      @(negedge clock);
      start = 1'b0;
   endtask

   // Bounded wait until the monitor has seen the given number of done pulses
   task automatic waitDone(input int target);
      bit seen;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         #1;
         if (doneCount >= target) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("[TB] FAIL done_timeout got=%0d expected=%0d", doneCount, target);
      end
   endtask

   initial begin
      int busyCycles;
      int base;
      logic [WIDTH:0] model;

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;

      // Reset state
      repeat (2) @(negedge clock);
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_done", 32'(done), 0);
      checkOutput("reset_diff", 32'(diff), 0);
      checkOutput("reset_bout", 32'(bout), 0);
      rst_n = 1'b1;
      @(negedge clock);

      // 15 - 8 - 1 = 6, and busy must span exactly WIDTH cycles
      base = doneCount;
      applyStimulus(4'b1111, 4'b1000, 1'b1, 4'b0110, 1'b0);
      busyCycles = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy) busyCycles++;
         if (done) break;
         @(negedge clock);
      end
      checkOutput("busy_cycles", 32'(busyCycles), WIDTH);
      waitDone(base + 1);
      repeat (3) @(negedge clock);
      checkOutput("hold_diff", 32'(diff), 32'h6);
      checkOutput("hold_bout", 32'(bout), 0);
      checkOutput("hold_done_low", 32'(done), 0);

      // Directed underflow and equal-operand cases
      base = doneCount;
      applyStimulus(4'd0, 4'd1, 1'b0, 4'b1111, 1'b1);
      waitDone(base + 1);
      applyStimulus(4'd5, 4'd5, 1'b0, 4'b0000, 1'b0);
      waitDone(base + 2);
      applyStimulus(4'd0, 4'd0, 1'b1, 4'b1111, 1'b1);
      waitDone(base + 3);

      // Start during RUN must be ignored: 10 - 3 = 7, single done pulse
      base = doneCount;
      applyStimulus(4'd10, 4'd3, 1'b0, 4'd7, 1'b0);
      @(negedge clock);
      a     = 4'd3;
      b     = 4'd1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      waitDone(base + 1);
      repeat (6) @(negedge clock);
      checkOutput("single_done", 32'(doneCount), 32'(base + 1));

      // Back-to-back: start held high through DONE launches 9 - 2 = 7 immediately
      base = doneCount;
      @(negedge clock);
      a     = 4'd6;
      b     = 4'd1;
      bin   = 1'b0;
      start = 1'b1;
      expQueue.push_back({1'b0, 4'd5});
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (done) break;
      end
      a = 4'd9;
      b = 4'd2;
      expQueue.push_back({1'b0, 4'd7});
      @(negedge clock);
      start = 1'b0;
      checkOutput("b2b_busy", 32'(busy), 1);
      waitDone(base + 2);

      // Asynchronous reset in the middle of RUN aborts without a done pulse
      base = doneCount;
      @(negedge clock);
      a     = 4'd7;
      b     = 4'd2;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      @(posedge clock);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy), 0);
      checkOutput("abort_done", 32'(done), 0);
      checkOutput("abort_diff", 32'(diff), 0);
      checkOutput("abort_bout", 32'(bout), 0);
      @(negedge clock);
      rst_n = 1'b1;
      repeat (6) @(negedge clock);
      checkOutput("abort_no_done", 32'(doneCount), 32'(base));
      applyStimulus(4'd12, 4'd4, 1'b0, 4'd8, 1'b0);
      waitDone(base + 1);

      // Exhaustive sweep against the {bout,diff} arithmetic model
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               base  = doneCount;
               model = (WIDTH+1)'(ia) - (WIDTH+1)'(ib) - (WIDTH+1)'(ic);
               applyStimulus(WIDTH'(ia), WIDTH'(ib), 1'(ic), model[WIDTH-1:0], model[WIDTH]);
               waitDone(base + 1);
            end
         end
      end

      repeat (4) @(negedge clock);
      checkOutput("queue_empty", 32'(expQueue.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
